config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per scan_clk half-period (legal values 1..255).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the bit-count input and counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port chain_sel  input  1  target chain: 0 = CLB chain, 1 = connection (SB/CB) chain.
REQ-007 SHALL have port total_bits  input  CNT_WIDTH  number of bits to shift.
REQ-008 SHALL have port word_valid  input  1  config byte available.
REQ-009 SHALL have port word_data  input  8  config byte, transmitted MSB first.
REQ-010 SHALL have port word_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port scan_clk  output  1  generated scan clock, registered.
REQ-012 SHALL have ports clb_scan_in, clb_scan_en  output  1 each  CLB chain data and enable.
REQ-013 SHALL have ports conn_scan_in, conn_scan_en  output  1 each  connection chain data and enable.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port bits_sent  output  CNT_WIDTH  scan_clk rising edges issued in the current or last load.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE; all outputs registered.
REQ-018 IDLE: on start=1 with total_bits!=0, SHALL latch total_bits and chain_sel, clear bits_sent, and enter LOAD; busy and the selected scan_en go to 1 the next cycle.
REQ-019 IDLE: on start=1 with total_bits==0, SHALL enter DONE directly, issue no scan_clk edge, and leave bits_sent=0.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 LOAD: word_ready=1; on word_valid&&word_ready, SHALL load the byte into an 8-bit shift register and enter SHIFT_LO; word_ready SHALL be 0 in all other states.
REQ-022 Stall in LOAD without word_valid: scan_clk held 0; scan_en held 1; no timeout.
REQ-023 SHIFT_LO: scan_clk=0; selected scan_in = current shift-register MSB, stable for the full bit period; duration CLK_DIV cycles, then SHIFT_HI.
REQ-024 SHIFT_HI: scan_clk=1 for CLK_DIV cycles; on exit, bits_sent increments by 1 and the shift register shifts left.
REQ-025 After SHIFT_HI: bits_sent==total_bits -> DONE; else 8 bits of current byte used -> LOAD; else -> SHIFT_LO.
REQ-026 A final partial byte SHALL transmit only its top (total_bits mod 8) bits; the remainder is discarded.
REQ-027 DONE: scan_clk=0, both scan_en=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-028 The non-selected chain's scan_in and scan_en SHALL be 0 for the whole load.
REQ-029 bits_sent SHALL hold its final value in IDLE until the next accepted start.
REQ-030 Each bit SHALL occupy exactly 2*CLK_DIV clk cycles when no LOAD stall occurs.

Reset
REQ-031 reset=1 SHALL, on the next rising clk edge, force IDLE with scan_clk, both scan_in, both scan_en, word_ready, busy, done = 0 and bits_sent = 0.
REQ-032 reset mid-load SHALL abort without a done pulse; a partial scan_clk high phase SHALL be truncated to 0.
REQ-033 reset SHALL take priority over start and over the word handshake in the same cycle.

Verification
REQ-034 CLK_DIV=2, chain_sel=0, total_bits=8, byte 0xA5 presented immediately -> clb_scan_in sampled at scan_clk rises = 1,0,1,0,0,1,0,1; 8 rises; conn_scan_en stays 0; done pulses once; bits_sent=8.
REQ-035 chain_sel=1, total_bits=12, bytes 0xF0 then 0x3C -> conn_scan_in = 1111 0000 0011; 12 rises; second byte's low nibble discarded; bits_sent=12.
REQ-036 total_bits=8, word_valid withheld 20 cycles after LOAD entry -> scan_clk stays 0 and scan_en stays 1 throughout; shifting resumes after handshake; result identical to the unstalled case.
REQ-037 start with total_bits=0 -> done pulses 2 cycles after start, no scan_clk edges, scan_en never asserted.
REQ-038 reset asserted during SHIFT_HI of bit 3 -> all outputs 0 next cycle, no done pulse; a following start with total_bits=8 completes normally.
REQ-039 start re-pulsed while busy -> ignored; bits_sent and the transmitted stream unchanged.

Source files
------------

// File: rtl/config_loader.sv
// rtl/config_loader.sv - byte-fed serial scan-chain loader with divided scan clock
// Output flops follow the FSM state one cycle behind; word_ready tracks the next state so the byte handshake is exact.
module config_loader #(
  parameter int CLK_DIV   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 chain_sel,
  input  logic [CNT_WIDTH-1:0] total_bits,
  input  logic                 word_valid,
  input  logic [7:0]           word_data,
  output logic                 word_ready,
  output logic                 scan_clk,
  output logic                 clb_scan_in,
  output logic                 clb_scan_en,
  output logic                 conn_scan_in,
  output logic                 conn_scan_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] bits_sent
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic                 sel_q, sel_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0] bits_sent_q, bits_sent_d;
  logic [CNT_WIDTH-1:0] bits_inc;
  logic                 div_last;

  logic word_ready_q, word_ready_d;
  logic scan_clk_q, scan_clk_d;
  logic clb_in_q, clb_in_d, clb_en_q, clb_en_d;
  logic conn_in_q, conn_in_d, conn_en_q, conn_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic shifting, active;

  assign bits_inc = bits_sent_q + CNT_WIDTH'(1);
  assign div_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    sel_d       = sel_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    div_cnt_d   = div_cnt_q;
    bits_sent_d = bits_sent_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bits_sent_d = '0;
          if (total_bits != '0) begin
            total_d = total_bits;
            sel_d   = chain_sel;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (word_valid && word_ready_q) begin
          shreg_d   = word_data;
          bit_idx_d = 3'd0;
          div_cnt_d = 8'd0;
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          div_cnt_d = 8'd0;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_cnt_d   = 8'd0;
          bits_sent_d = bits_inc;
          shreg_d     = {shreg_q[6:0], 1'b0};
          bit_idx_d   = bit_idx_q + 3'd1;
          if (bits_inc == total_q)   state_d = ST_DONE;
          else if (bit_idx_q == 3'd7) state_d = ST_LOAD;
          else                        state_d = ST_SHIFT_LO;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shifting     = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    active       = shifting || (state_q == ST_LOAD);
    word_ready_d = (state_d == ST_LOAD);
    scan_clk_d   = (state_q == ST_SHIFT_HI);
    busy_d       = active;
    done_d       = (state_q == ST_DONE);
    clb_en_d     = active && !sel_q;
    conn_en_d    = active && sel_q;
    clb_in_d     = shifting && !sel_q && shreg_q[7];
    conn_in_d    = shifting && sel_q && shreg_q[7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      total_q      <= '0;
      sel_q        <= 1'b0;
      shreg_q      <= 8'd0;
      bit_idx_q    <= 3'd0;
      div_cnt_q    <= 8'd0;
      bits_sent_q  <= '0;
      word_ready_q <= 1'b0;
      scan_clk_q   <= 1'b0;
      clb_in_q     <= 1'b0;
      clb_en_q     <= 1'b0;
      conn_in_q    <= 1'b0;
      conn_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      sel_q        <= sel_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      div_cnt_q    <= div_cnt_d;
      bits_sent_q  <= bits_sent_d;
      word_ready_q <= word_ready_d;
      scan_clk_q   <= scan_clk_d;
      clb_in_q     <= clb_in_d;
      clb_en_q     <= clb_en_d;
      conn_in_q    <= conn_in_d;
      conn_en_q    <= conn_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_ready   = word_ready_q;
  assign scan_clk     = scan_clk_q;
  assign clb_scan_in  = clb_in_q;
  assign clb_scan_en  = clb_en_q;
  assign conn_scan_in = conn_in_q;
  assign conn_scan_en = conn_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bits_sent    = bits_sent_q;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - randomized scoreboard bench for config_loader
module tb_config_loader;
  localparam int CLK_DIV   = 2;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset, start, chain_sel, word_valid;
  logic [CNT_WIDTH-1:0] total_bits;
  logic [7:0]           word_data;
  logic                 word_ready, scan_clk, clb_scan_in, clb_scan_en;
  logic                 conn_scan_in, conn_scan_en, busy, done;
  logic [CNT_WIDTH-1:0] bits_sent;

  config_loader #(.CLK_DIV(CLK_DIV), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .chain_sel(chain_sel),
    .total_bits(total_bits), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .scan_clk(scan_clk), .clb_scan_in(clb_scan_in),
    .clb_scan_en(clb_scan_en), .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en),
    .busy(busy), .done(done), .bits_sent(bits_sent)
  );

  always #5 clk = ~clk;

  typedef struct { logic b; bit first; } exp_t;
  exp_t       exp_q[$];
  int         exp_done_q[$];
  logic [7:0] cur_bytes[$];
  bit         exp_sel;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic sel_in();
    return exp_sel ? conn_scan_in : clb_scan_in;
  endfunction
  function automatic logic sel_en();
    return exp_sel ? conn_scan_en : clb_scan_en;
  endfunction

  // Monitor: pops the expected stream on every scan_clk rise and the expected count on every done.
  initial begin
    logic prev_clk, rise_val;
    int   since_rise;
    exp_t e;
    prev_clk = 1'b0; rise_val = 1'b0; since_rise = 0;
    forever begin
      @(negedge clk);
      since_rise++;
      if (reset) begin
        prev_clk = 1'b0;
      end else begin
        if (scan_clk && !prev_clk) begin
          if (exp_q.size() == 0) begin
            chk("extra_scan_rise", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("scan_bit", sel_in(), e.b);
            chk("sel_scan_en", sel_en(), 1);
            chk("other_chain", exp_sel ? {clb_scan_en, clb_scan_in} : {conn_scan_en, conn_scan_in}, 0);
            if (!e.first) chk("bit_period", since_rise, 2 * CLK_DIV);
          end
          rise_val = sel_in();
          since_rise = 0;
        end else if (scan_clk && prev_clk) begin
          chk("scan_in_stable", sel_in(), rise_val);
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("bits_sent_at_done", bits_sent, exp_done_q.pop_front());
            chk("bits_left_at_done", exp_q.size(), 0);
            chk("busy_at_done", {busy, scan_clk, clb_scan_en, conn_scan_en}, 0);
          end
        end
      end
      prev_clk = scan_clk;
    end
  end

  task automatic fill_random(input int nbytes);
    cur_bytes.delete();
    for (int i = 0; i < nbytes; i++) cur_bytes.push_back(8'($urandom));
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (word_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("word_ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  // abort_at >= 0: assert reset during the high phase of that bit instead of completing.
  task automatic do_load(input bit sel, input int total, input int max_stall,
                         input int stall_first, input bit repulse, input int abort_at);
    logic [7:0] b;
    bit ok;
    exp_sel = sel;
    for (int i = 0; i < total; i++) begin
      b = cur_bytes[i / 8];
      exp_q.push_back('{b: b[7 - (i % 8)], first: (i % 8) == 0});
    end
    exp_done_q.push_back(total);
    @(negedge clk);
    start = 1'b1; chain_sel = sel; total_bits = CNT_WIDTH'(total);
    @(negedge clk);
    start = 1'b0; chain_sel = 1'($urandom); total_bits = CNT_WIDTH'($urandom_range(0, 50));
    for (int k = 0; k < (total + 7) / 8; k++) begin
      wait_ready(ok);
      if (!ok) break;
      if (k == 0) begin
        for (int s = 0; s < stall_first; s++) begin
          @(negedge clk);
          chk("stall_scan_clk", scan_clk, 0);
          chk("stall_scan_en", sel_en(), 1);
        end
      end
      repeat ($urandom_range(0, max_stall)) @(negedge clk);
      if (repulse && k == 1) begin
        chk("busy_before_repulse", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      word_valid = 1'b1; word_data = cur_bytes[k];
      @(posedge clk);
      #1 word_valid = 1'b0; word_data = 8'($urandom);
    end
    if (abort_at >= 0) begin
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (scan_clk && bits_sent == CNT_WIDTH'(abort_at)) begin ok = 1'b1; break; end
      end
      if (!ok) chk("abort_point_timeout", 0, 1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete(); exp_done_q.delete();
      @(negedge clk);
      chk("abort_outputs", {scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                            word_ready, busy, done}, 0);
      chk("abort_bits_sent", bits_sent, 0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("no_done_after_abort", done, 0);
      end
    end else begin
      wait_done();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("bits_sent_hold", bits_sent, total);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chain_sel = 1'b0; total_bits = '0;
    word_valid = 1'b0; word_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {word_ready, scan_clk, clb_scan_in, clb_scan_en, conn_scan_in,
                          conn_scan_en, busy, done}, 0);
    chk("reset_bits_sent", bits_sent, 0);
    reset = 1'b0;

    cur_bytes = '{8'hA5};
    do_load(1'b0, 8, 0, 0, 1'b0, -1);

    cur_bytes = '{8'hF0, 8'h3C};
    do_load(1'b1, 12, 0, 0, 1'b0, -1);

    cur_bytes = '{8'hA5};
    do_load(1'b0, 8, 0, 20, 1'b0, -1);

    // Zero-length load: done two cycles after start, nothing shifted, no enable.
    exp_done_q.push_back(0);
    @(negedge clk);
    start = 1'b1; chain_sel = 1'b1; total_bits = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_early", done, 0);
    chk("zero_en_early", {clb_scan_en, conn_scan_en, busy}, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 1);
    chk("zero_en", {clb_scan_en, conn_scan_en, scan_clk}, 0);
    @(negedge clk);
    chk("zero_done_once", done, 0);

    fill_random(1);
    do_load(1'b0, 8, 0, 0, 1'b0, 3);
    fill_random(1);
    do_load(1'b0, 8, 0, 0, 1'b0, -1);

    fill_random(3);
    do_load(1'b1, 20, 2, 0, 1'b1, -1);

    for (int n = 0; n < 25; n++) begin
      int tot;
      tot = $urandom_range(1, 40);
      fill_random((tot + 7) / 8);
      do_load(1'($urandom), tot, 3, 0, 1'($urandom_range(0, 3) == 0 && tot > 8), -1);
    end

    repeat (5) @(negedge clk);
    chk("final_exp_bits_empty", exp_q.size(), 0);
    chk("final_exp_done_empty", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
